// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen encoding and width helpers for the game-flow controller
package game_pkg;

    typedef enum logic [2:0] {
        S_INIT           = 3'd0,
        S_CAR_SELECT     = 3'd1,
        S_CONTROL_SELECT = 3'd2,
        S_GAME           = 3'd3,
        S_PAUSE          = 3'd4,
        S_RESULT         = 3'd5
    } state_t;

    localparam int N_SCREENS = 6;

    // Selection index width; a single choice still gets a 1-bit port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - saturating frame counter with a pulse on the limit-th tick
module frame_timer #(
    parameter int W = 8
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         clear,
    input  logic         frame_tick,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt;

    // done must not depend on clear: clear is derived from the transition done causes.
    assign done = frame_tick && (cnt == (limit - W'(1)));

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (frame_tick && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/game_flow_fsm.sv
// rtl/game_flow_fsm.sv - screen sequencer driving layer visibility and player selections
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int SPLASH_FRAMES = 120,
    parameter int RESULT_FRAMES = 180,
    parameter int N_CARS        = 4,
    parameter int N_CTRL        = 2,
    localparam int CW           = sel_width(N_CARS),
    localparam int KW           = sel_width(N_CTRL)
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          btn_confirm,
    input  logic          btn_back,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          race_done,
    output logic          splash_visible,
    output logic          car_select_visible,
    output logic          control_select_visible,
    output logic          track_visible,
    output logic          player_visible,
    output logic          result_visible,
    output logic          game_run,
    output logic [CW-1:0] car_sel,
    output logic [KW-1:0] ctrl_sel
);

    localparam int MAX_FRAMES = (SPLASH_FRAMES > RESULT_FRAMES) ? SPLASH_FRAMES : RESULT_FRAMES;
    localparam int TW         = $clog2(MAX_FRAMES + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] car_nxt;
    logic [KW-1:0] ctrl_nxt;
    logic [6:0]    flags_nxt;
    logic [6:0]    flags_q;
    logic          timer_clear;
    logic          timer_done;
    logic [TW-1:0] timer_limit;

    logic move_right;
    logic move_left;

    assign move_right  = btn_right && !btn_left;
    assign move_left   = btn_left && !btn_right;
    assign timer_clear = (state_nxt != state);
    assign timer_limit = (state == S_RESULT) ? TW'(RESULT_FRAMES) : TW'(SPLASH_FRAMES);

    frame_timer #(
        .W(TW)
    ) u_frame_timer (
        .pclk      (pclk),
        .rst       (rst),
        .clear     (timer_clear),
        .frame_tick(frame_tick),
        .limit     (timer_limit),
        .done      (timer_done)
    );

    always_comb begin
        state_nxt = state;
        car_nxt   = car_sel;
        ctrl_nxt  = ctrl_sel;
        case (state)
            S_INIT: begin
                if (btn_confirm || timer_done) state_nxt = S_CAR_SELECT;
            end
            S_CAR_SELECT: begin
                if (btn_confirm) begin
                    state_nxt = S_CONTROL_SELECT;
                end else if (btn_back) begin
                    state_nxt = S_INIT;
                end else if (move_right) begin
                    car_nxt = (car_sel == CW'(N_CARS - 1)) ? '0 : car_sel + CW'(1);
                end else if (move_left) begin
                    car_nxt = (car_sel == '0) ? CW'(N_CARS - 1) : car_sel - CW'(1);
                end
            end
            S_CONTROL_SELECT: begin
                if (btn_confirm) begin
                    state_nxt = S_GAME;
                end else if (btn_back) begin
                    state_nxt = S_CAR_SELECT;
                end else if (move_right) begin
                    ctrl_nxt = (ctrl_sel == KW'(N_CTRL - 1)) ? '0 : ctrl_sel + KW'(1);
                end else if (move_left) begin
                    ctrl_nxt = (ctrl_sel == '0) ? KW'(N_CTRL - 1) : ctrl_sel - KW'(1);
                end
            end
            S_GAME: begin
                if (race_done) state_nxt = S_RESULT;
                else if (btn_back) state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (btn_confirm) state_nxt = S_GAME;
                else if (btn_back) state_nxt = S_CAR_SELECT;
            end
            S_RESULT: begin
                if (btn_confirm || timer_done) state_nxt = S_CAR_SELECT;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Flag order: splash, car, control, track, player, result, run.
    always_comb begin
        flags_nxt = 7'b0000000;
        case (state_nxt)
            S_INIT:           flags_nxt = 7'b1000000;
            S_CAR_SELECT:     flags_nxt = 7'b0100000;
            S_CONTROL_SELECT: flags_nxt = 7'b0010000;
            S_GAME:           flags_nxt = 7'b0001101;
            S_PAUSE:          flags_nxt = 7'b0001100;
            S_RESULT:         flags_nxt = 7'b0001010;
            default:          flags_nxt = 7'b1000000;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= S_INIT;
            car_sel  <= '0;
            ctrl_sel <= '0;
            flags_q  <= '0;
        end else begin
            state    <= state_nxt;
            car_sel  <= car_nxt;
            ctrl_sel <= ctrl_nxt;
            flags_q  <= flags_nxt;
        end
    end

    assign splash_visible         = flags_q[6];
    assign car_select_visible     = flags_q[5];
    assign control_select_visible = flags_q[4];
    assign track_visible          = flags_q[3];
    assign player_visible         = flags_q[2];
    assign result_visible         = flags_q[1];
    assign game_run               = flags_q[0];

endmodule

// File: tb/tb_game_flow_fsm.sv
// tb/tb_game_flow_fsm.sv - scoreboard bench for game_flow_fsm against a screen-level model
module tb_game_flow_fsm;

    localparam int SPLASH = 3;
    localparam int RESULT = 2;
    localparam int NCARS  = 3;
    localparam int NCTRL  = 2;

    typedef logic [9:0] vec_t;

    bit   pclk = 1'b0;
    logic rst, frame_tick, btn_confirm, btn_back, btn_left, btn_right, race_done;
    logic splash_visible, car_select_visible, control_select_visible;
    logic track_visible, player_visible, result_visible, game_run;
    logic [1:0] car_sel;
    logic [0:0] ctrl_sel;

    always #5 pclk = ~pclk;

    game_flow_fsm #(
        .SPLASH_FRAMES(SPLASH),
        .RESULT_FRAMES(RESULT),
        .N_CARS       (NCARS),
        .N_CTRL       (NCTRL)
    ) dut (
        .pclk                  (pclk),
        .rst                   (rst),
        .frame_tick            (frame_tick),
        .btn_confirm           (btn_confirm),
        .btn_back              (btn_back),
        .btn_left              (btn_left),
        .btn_right             (btn_right),
        .race_done             (race_done),
        .splash_visible        (splash_visible),
        .car_select_visible    (car_select_visible),
        .control_select_visible(control_select_visible),
        .track_visible         (track_visible),
        .player_visible        (player_visible),
        .result_visible        (result_visible),
        .game_run              (game_run),
        .car_sel               (car_sel),
        .ctrl_sel              (ctrl_sel)
    );

    vec_t  exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    string m_scr    = "INIT";
    int    m_frames = 0;
    int    m_car    = 0;
    int    m_ctrl   = 0;

    function automatic logic [6:0] screen_flags(input string s);
        if (s == "INIT")   return 7'b1000000;
        if (s == "CAR")    return 7'b0100000;
        if (s == "CTRL")   return 7'b0010000;
        if (s == "GAME")   return 7'b0001101;
        if (s == "PAUSE")  return 7'b0001100;
        if (s == "RESULT") return 7'b0001010;
        return 7'b0000000;
    endfunction

    task automatic model_step(input bit r, ft, c, b, l, rt, rd, output vec_t e);
        string nxt;
        if (r) begin
            m_scr = "INIT"; m_frames = 0; m_car = 0; m_ctrl = 0;
            e = '0;
            return;
        end
        nxt = m_scr;
        if (m_scr == "INIT") begin
            if (c || (ft && (m_frames + 1 == SPLASH))) nxt = "CAR";
        end else if (m_scr == "CAR") begin
            if (c) nxt = "CTRL";
            else if (b) nxt = "INIT";
            else if (rt && !l) m_car = (m_car + 1) % NCARS;
            else if (l && !rt) m_car = (m_car + NCARS - 1) % NCARS;
        end else if (m_scr == "CTRL") begin
            if (c) nxt = "GAME";
            else if (b) nxt = "CAR";
            else if (rt && !l) m_ctrl = (m_ctrl + 1) % NCTRL;
            else if (l && !rt) m_ctrl = (m_ctrl + NCTRL - 1) % NCTRL;
        end else if (m_scr == "GAME") begin
            if (rd) nxt = "RESULT";
            else if (b) nxt = "PAUSE";
        end else if (m_scr == "PAUSE") begin
            if (c) nxt = "GAME";
            else if (b) nxt = "CAR";
        end else if (m_scr == "RESULT") begin
            if (c || (ft && (m_frames + 1 == RESULT))) nxt = "CAR";
        end
        if (nxt != m_scr) m_frames = 0;
        else if (ft) m_frames = m_frames + 1;
        m_scr = nxt;
        e = {screen_flags(m_scr), 2'(m_car), 1'(m_ctrl)};
    endtask

    task automatic apply(input bit r, ft, c, b, l, rt, rd);
        vec_t e;
        rst = r; frame_tick = ft; btn_confirm = c; btn_back = b;
        btn_left = l; btn_right = rt; race_done = rd;
        model_step(r, ft, c, b, l, rt, rd, e);
        exp_q.push_back(e);
        @(posedge pclk);
        #2;
    endtask

    vec_t mon_exp, mon_act;
    always @(negedge pclk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {splash_visible, car_select_visible, control_select_visible,
                       track_visible, player_visible, result_visible, game_run,
                       car_sel, ctrl_sel};
            vectors = vectors + 1;
            if (mon_act !== mon_exp) begin
                miscompares = miscompares + 1;
                $display("FAIL vec%0d flags/car/ctrl got %b required %b", vectors, mon_act, mon_exp);
            end
        end
    end

    initial begin
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 0, 0);
        // Splash timeout on the 3rd tick
        apply(0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        // Car wrap: right x3, left from 0, left+right
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1, 1, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        // Game, pause, resume, race_done beats back
        apply(0, 0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 1);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        // Back paths and splash counter restart
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        // Reset mid-race
        apply(1, 0, 1, 1, 0, 1, 1);
        apply(0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 8) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0));
        end

        rst = 0; frame_tick = 0; btn_confirm = 0; btn_back = 0;
        btn_left = 0; btn_right = 0; race_done = 0;
        repeat (3) @(negedge pclk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
